// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file scan reader.
package regfile_pkg;

  localparam int unsigned DEF_N    = 4;
  localparam int unsigned DEF_REGS = 4;

  // Index width for a register count; a single register still gets one bit.
  function automatic int unsigned idx_w(input int unsigned regs);
    return (regs > 1) ? $clog2(regs) : 1;
  endfunction

  localparam int unsigned IDX_W = idx_w(DEF_REGS);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/regfile_scan_reader_if.sv
// Read port between the scan reader (master) and the register file (slave).
interface regfile_scan_reader_if
  import regfile_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned REGS = DEF_REGS
);

  localparam int unsigned IW = idx_w(REGS);

  logic          oRdEn;
  logic [IW-1:0] oRdIndex;
  logic [N-1:0]  iRdData;

  modport master (
    output oRdEn,
    output oRdIndex,
    input  iRdData
  );

  modport slave (
    input  oRdEn,
    input  oRdIndex,
    output iRdData
  );

endinterface

// File: rtl/RiseDetect.sv
// One-cycle rising-edge pulse. The "was low" history resets to 0, so a level
// already high when reset releases must drop to 0 before it can fire.
module RiseDetect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse_c
);

  logic was_low;

  // Remember whether the input was low on the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      was_low <= 1'b0;
    end else begin
      was_low <= ~d;
    end
  end

  assign pulse_c = d & was_low;

endmodule

// File: rtl/regfile_scan_reader.sv
// Sweeps a register file index by index, holding each read value for DWELL
// cycles and reporting the sum of each completed sweep.
module regfile_scan_reader
  import regfile_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned REGS  = DEF_REGS,
  parameter int unsigned DWELL = 10_000_000
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       iStart,
  input  logic                       iCont,
  regfile_scan_reader_if.master      rf,
  output logic [N-1:0]               oValue,
  output logic [idx_w(REGS)-1:0]     oValueIndex,
  output logic                       oValid,
  output logic                       oBusy,
  output logic                       oDone,
  output logic [N+idx_w(REGS)-1:0]   oSum
);

  localparam int unsigned IW = idx_w(REGS);
  localparam int unsigned SW = N + IW;
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t        state, state_next;
  logic [IW-1:0] idx, idx_next;
  logic [SW-1:0] acc, acc_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [N-1:0]  value_next;
  logic [IW-1:0] value_idx_next;
  logic          valid_next;
  logic [SW-1:0] sum_next;
  logic          rd_en_next;
  logic [IW-1:0] rd_index_next;
  logic          busy_next;
  logic          done_next;
  logic          start_c;

  RiseDetect u_start_edge (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .d       (iStart),
    .pulse_c (start_c)
  );

  // State and registered outputs; outputs are derived from the next state so
  // they line up with the state they describe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      cnt         <= '0;
      oValue      <= '0;
      oValueIndex <= '0;
      oValid      <= 1'b0;
      oSum        <= '0;
      rf.oRdEn    <= 1'b0;
      rf.oRdIndex <= '0;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      acc         <= acc_next;
      cnt         <= cnt_next;
      oValue      <= value_next;
      oValueIndex <= value_idx_next;
      oValid      <= valid_next;
      oSum        <= sum_next;
      rf.oRdEn    <= rd_en_next;
      rf.oRdIndex <= rd_index_next;
      oBusy       <= busy_next;
      oDone       <= done_next;
    end
  end

  // Sweep sequencing: issue read, capture data, dwell, then advance or finish.
  always_comb begin
    state_next     = state;
    idx_next       = idx;
    acc_next       = acc;
    cnt_next       = cnt;
    value_next     = oValue;
    value_idx_next = oValueIndex;
    valid_next     = oValid;
    sum_next       = oSum;

    unique case (state)
      IDLE: begin
        if (start_c) begin
          idx_next   = '0;
          acc_next   = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        value_next     = rf.iRdData;
        value_idx_next = idx;
        valid_next     = 1'b1;
        acc_next       = acc + SW'(rf.iRdData);
        cnt_next       = CW'(DWELL - 1);
        state_next     = HOLD;
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
        end else if (idx != IW'(REGS - 1)) begin
          idx_next   = idx + IW'(1);
          state_next = ISSUE;
        end else begin
          // The final term was already folded in during CAPTURE.
          sum_next   = acc;
          state_next = DONE;
        end
      end
      DONE: begin
        if (iCont) begin
          idx_next   = '0;
          acc_next   = '0;
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    rd_en_next    = (state_next == ISSUE);
    rd_index_next = rd_en_next ? idx_next : '0;
    busy_next     = (state_next != IDLE);
    done_next     = (state_next == DONE);
  end

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Directed bench for regfile_scan_reader with DWELL=3, N=4, REGS=4.
module tb_regfile_scan_reader;

  logic       Clk;
  logic       Reset_n;
  logic       iStart;
  logic       iCont;
  logic [3:0] oValue;
  logic [1:0] oValueIndex;
  logic       oValid;
  logic       oBusy;
  logic       oDone;
  logic [5:0] oSum;

  logic [3:0] regs [4];

  int vectors = 0;
  int miscompares = 0;

  regfile_scan_reader_if #(.N(4), .REGS(4)) rf ();

  regfile_scan_reader #(.N(4), .REGS(4), .DWELL(3)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .iStart      (iStart),
    .iCont       (iCont),
    .rf          (rf),
    .oValue      (oValue),
    .oValueIndex (oValueIndex),
    .oValid      (oValid),
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oSum        (oSum)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file model: data appears the cycle after the read request.
  always @(posedge Clk) begin
    if (rf.oRdEn) rf.iRdData <= regs[rf.oRdIndex];
  end

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rf.oRdEn), 0);
    chk({tag, "_rd_idx"}, 32'(rf.oRdIndex), 0);
    chk({tag, "_value"}, 32'(oValue), 0);
    chk({tag, "_vidx"}, 32'(oValueIndex), 0);
    chk({tag, "_valid"}, 32'(oValid), 0);
    chk({tag, "_busy"}, 32'(oBusy), 0);
    chk({tag, "_done"}, 32'(oDone), 0);
    chk({tag, "_sum"}, 32'(oSum), 0);
  endtask

  // Starts at the negedge of the first ISSUE cycle, ends at the DONE negedge.
  task automatic sweep(input logic [15:0] vals, input logic [5:0] esum,
                       input bit tog, input bit drop);
    for (int r = 0; r < 4; r++) begin
      chk("issue_rd_en", 32'(rf.oRdEn), 1);
      chk("issue_rd_idx", 32'(rf.oRdIndex), 32'(r));
      chk("issue_busy", 32'(oBusy), 1);
      tick();
      chk("capture_rd_en", 32'(rf.oRdEn), 0);
      tick();
      chk("hold_value", 32'(oValue), 32'(vals[4*r +: 4]));
      chk("hold_vidx", 32'(oValueIndex), 32'(r));
      chk("hold_valid", 32'(oValid), 1);
      for (int h = 0; h < 3; h++) begin
        chk("hold_rd_en", 32'(rf.oRdEn), 0);
        chk("hold_done", 32'(oDone), 0);
        chk("hold_busy", 32'(oBusy), 1);
        if (tog) iStart = ~iStart;
        if (drop && r == 1 && h == 0) iCont = 1'b0;
        tick();
      end
    end
    chk("done_pulse", 32'(oDone), 1);
    chk("done_sum", 32'(oSum), 32'(esum));
    chk("done_busy", 32'(oBusy), 1);
    chk("done_rd_en", 32'(rf.oRdEn), 0);
  endtask

  initial begin
    Reset_n = 1'b0;
    iStart  = 1'b0;
    iCont   = 1'b0;
    regs[0] = 4'h3; regs[1] = 4'h7; regs[2] = 4'hA; regs[3] = 4'hF;

    // Reset state
    @(negedge Clk);
    chk_all_zero("reset");
    Reset_n = 1'b1;
    tick();

    // Single sweep over {3,7,A,F}
    iStart = 1'b1;
    tick();
    sweep(16'hFA73, 6'h23, 1'b0, 1'b0);
    tick();
    chk("s1_idle_busy", 32'(oBusy), 0);
    chk("s1_idle_done", 32'(oDone), 0);
    chk("s1_idle_rd_en", 32'(rf.oRdEn), 0);
    chk("s1_hold_value", 32'(oValue), 32'hF);
    chk("s1_hold_vidx", 32'(oValueIndex), 3);
    chk("s1_hold_valid", 32'(oValid), 1);
    chk("s1_sum", 32'(oSum), 32'h23);
    iStart = 1'b0;
    tick();
    tick();
    chk("s1_single_done", 32'(oDone), 0);
    chk("s1_still_idle", 32'(oBusy), 0);

    // iStart toggling during HOLD must not restart or stretch the sweep
    iStart = 1'b1;
    tick();
    sweep(16'hFA73, 6'h23, 1'b1, 1'b0);
    tick();
    chk("tog_idle_busy", 32'(oBusy), 0);
    tick();
    chk("tog_level_no_start", 32'(oBusy), 0);

    // Continuous mode with all F, then iCont dropped mid-sweep
    regs[0] = 4'hF; regs[1] = 4'hF; regs[2] = 4'hF; regs[3] = 4'hF;
    iCont  = 1'b1;
    iStart = 1'b0;
    tick();
    iStart = 1'b1;
    tick();
    sweep(16'hFFFF, 6'h3C, 1'b0, 1'b0);
    tick();
    chk("cont_wrap_rd_en", 32'(rf.oRdEn), 1);
    chk("cont_wrap_idx", 32'(rf.oRdIndex), 0);
    chk("cont_wrap_done", 32'(oDone), 0);
    chk("cont_wrap_vidx", 32'(oValueIndex), 3);
    sweep(16'hFFFF, 6'h3C, 1'b0, 1'b1);
    tick();
    chk("drop_idle_busy", 32'(oBusy), 0);
    chk("drop_idle_done", 32'(oDone), 0);
    chk("drop_idle_rd_en", 32'(rf.oRdEn), 0);

    // Reset in HOLD of index 2, with iStart held high through release
    regs[0] = 4'h3; regs[1] = 4'h7; regs[2] = 4'hA; regs[3] = 4'hF;
    iStart = 1'b0;
    tick();
    iStart = 1'b1;
    tick();
    repeat (12) tick();
    chk("pre_reset_vidx", 32'(oValueIndex), 2);
    chk("pre_reset_busy", 32'(oBusy), 1);
    Reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) tick();
    chk("held_start_busy", 32'(oBusy), 0);
    chk("held_start_rd_en", 32'(rf.oRdEn), 0);
    iStart = 1'b0;
    tick();
    iStart = 1'b1;
    tick();
    sweep(16'hFA73, 6'h23, 1'b0, 1'b0);
    tick();
    chk("post_reset_idle", 32'(oBusy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_scan_reader.md
REGFILE_SCAN_READER -- requirements
Module: regfile_scan_reader

Interface
REQ-001 SHALL have parameter N, default 4: register data width in bits.
REQ-002 SHALL have parameter REGS, default 4: number of registers scanned, indices 0..REGS-1, where REGS is a power of two.
REQ-003 SHALL have parameter DWELL, default 10_000_000: cycles each value is held (1 s at 10 MHz), DWELL >= 1.
REQ-004 SHALL have a single clock and an asynchronous active-low reset: Clk  in  1  rising-edge clock.
REQ-005 SHALL have Reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have iStart  in  1  level input; its rising edge starts a sweep.
REQ-007 SHALL have iCont  in  1  continuous mode; 1 = repeat sweeps, 0 = single sweep.
REQ-008 SHALL have oRdEn  out  1  read request to the register file, one cycle wide.
REQ-009 SHALL have oRdIndex  out  log2(REGS)  register index to read, valid while oRdEn=1.
REQ-010 SHALL have iRdData  in  N  read data, valid exactly one cycle after oRdEn.
REQ-011 SHALL have oValue  out  N  last captured register value.
REQ-012 SHALL have oValueIndex  out  log2(REGS)  index of oValue.
REQ-013 SHALL have oValid  out  1  oValue is meaningful.
REQ-014 SHALL have oBusy  out  1  a sweep is in progress.
REQ-015 SHALL have oDone  out  1  one-cycle pulse at sweep end.
REQ-016 SHALL have oSum  out  N+log2(REGS)  sum of the last completed sweep.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, CAPTURE, HOLD, DONE.
REQ-018 SHALL start a sweep on an iStart rising edge (iStart=1 with previous-cycle iStart=0) in IDLE: clear index and accumulator, then go to ISSUE on the next cycle.
REQ-019 SHALL ignore iStart edges while in any state except IDLE.
REQ-020 SHALL, in ISSUE, assert oRdEn=1 with oRdIndex=index for exactly one cycle, then go to CAPTURE.
REQ-021 SHALL, in CAPTURE, register iRdData into oValue and index into oValueIndex, set oValid=1, add the zero-extended data to the accumulator, load the dwell counter with DWELL-1, and go to HOLD.
REQ-022 SHALL stay in HOLD while the dwell counter decrements; at 0 with index<REGS-1 it SHALL increment index and go to ISSUE.
REQ-023 SHALL, at dwell 0 with index=REGS-1, copy accumulator+final term into oSum and go to DONE.
REQ-024 SHALL, in DONE, pulse oDone for 1 cycle; then if iCont=1 go to ISSUE with index=0 and the accumulator cleared, else go to IDLE.
REQ-025 SHALL drive oBusy=1 in every state except IDLE.
REQ-026 SHALL hold oValue and oValid after the sweep ends until reset.
REQ-027 SHALL sample iCont only in DONE; a change of iCont mid-sweep SHALL have no effect until DONE.
REQ-028 SHALL never overflow the oSum width: REGS*(2^N-1) fits in N+log2(REGS) bits.
REQ-029 SHALL take 2+DWELL cycles per register, and DONE SHALL follow REGS*(2+DWELL) cycles after ISSUE is first entered.

Reset
REQ-030 SHALL, on Reset_n=0 at any time including mid-sweep, immediately force state IDLE and drive oRdEn=0, oRdIndex=0, oValue=0, oValueIndex=0, oValid=0, oBusy=0, oDone=0, oSum=0, with the counter and the start-edge history cleared.
REQ-031 SHALL NOT, after reset release, treat iStart already at 1 as an edge; iStart SHALL return to 0 first.

Structure
REQ-032 SHALL define the state enum, the default REGS and N, and the index width constant in shared package regfile_pkg.
REQ-033 SHALL use sub-module RiseDetect (one-cycle rising-edge pulse, async active-low reset) for iStart.

Verification (DWELL=3, N=4, REGS=4)
REQ-034 SHALL verify this: with registers = {3,7,A,F}, iCont=0, pulse iStart -> oRdEn at indices 0..3, 5 cycles apart; oValue 3,7,A,F; oSum=0x23; one oDone; then oBusy=0.
REQ-035 SHALL verify this: with iCont=1 and registers all F -> repeated sweeps, oSum=0x3C after each oDone, and index wraps 3->0.
REQ-036 SHALL verify this: iStart toggled during HOLD -> no restart, and sweep timing unchanged.
REQ-037 SHALL verify this: Reset_n low in HOLD of index 2 -> all outputs 0 immediately; a new iStart edge then starts at index 0.
REQ-038 SHALL verify this: iCont changed 1->0 mid-sweep -> sweep completes, then IDLE after oDone.
REQ-039 SHALL verify this: iStart held at 1 through reset release -> no sweep until 0->1.
